// File: rtl/fifo_ctrl_mem.sv
// Synchronous push/pop FIFO with internal storage, registered read data and occupancy flags.
// Optional sticky overflow/underflow reporting is enabled by defining FIFO_ERROR_FLAGS_EN.
module fifo_ctrl_mem #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] FIFO_data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] FIFO_data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic [1:0]            error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_TH   = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_TH   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

  // Handshake: a push is taken on a rising edge when push=1 and full=0; a pop is
  // taken when pop=1 and empty=0. Both decisions use the flags registered before
  // that edge, so an empty FIFO never reads through a same-cycle push.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push_acc;
  logic                  pop_acc;

  assign push_acc = push && !full;
  assign pop_acc  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= FIFO_data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
    end else if (push_acc) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_ptr <= '0;
    end else if (pop_acc) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fifo_count <= '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Read data holds its last value when no pop is taken; only valid_out pulses.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      FIFO_data_out <= '0;
      valid_out     <= 1'b0;
    end else begin
      valid_out <= pop_acc;
      if (pop_acc) begin
        FIFO_data_out <= mem[rd_ptr];
      end
    end
  end

  assign full         = (fifo_count == DEPTH_C);
  assign empty        = (fifo_count == '0);
  assign almost_full  = (fifo_count >= AF_TH);
  assign almost_empty = (fifo_count <= AE_TH);

`ifdef FIFO_ERROR_FLAGS_EN
  logic overflow;
  logic underflow;

  assign overflow  = push && full;
  assign underflow = pop && empty;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      error <= 2'b00;
    end else begin
      if (overflow)  error[1] <= 1'b1;
      if (underflow) error[0] <= 1'b1;
    end
  end
`else
  assign error = 2'b00;
`endif

endmodule

// File: tb/tb_fifo_ctrl_mem.sv
// Directed bench for fifo_ctrl_mem: stimulus tasks queue expected read words,
// a negedge monitor pops and compares them whenever valid_out is high.
module tb_fifo_ctrl_mem;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk;
  logic          reset_L;
  logic [DW-1:0] FIFO_data_in;
  logic          push;
  logic          pop;
  logic [DW-1:0] FIFO_data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   fifo_count;
  logic [1:0]    error;

  int tests = 0;
  int fails = 0;
  int n_exp_pops = 0;
  int n_valid = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_q[$];
  logic [1:0]    m_err;

  fifo_ctrl_mem #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)
  ) dut (
    .clk(clk), .reset_L(reset_L), .FIFO_data_in(FIFO_data_in), .push(push), .pop(pop),
    .FIFO_data_out(FIFO_data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .fifo_count(fifo_count),
    .error(error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [1:0] exp_err();
`ifdef FIFO_ERROR_FLAGS_EN
    return m_err;
`else
    return 2'b00;
`endif
  endfunction

  task automatic check_flags();
    int c;
    c = model_q.size();
    chk("fifo_count", 32'(fifo_count), 32'(c));
    chk("full", 32'(full), 32'(c == 8));
    chk("empty", 32'(empty), 32'(c == 0));
    chk("almost_full", 32'(almost_full), 32'(c >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(c <= 2));
    chk("error", 32'(error), 32'(exp_err()));
  endtask

  // driver: one clock of push/pop; the bench's own queue decides acceptance
  task automatic step(input logic p, input logic q, input logic [DW-1:0] d);
    logic pa, qa;
    @(negedge clk);
    push = p; pop = q; FIFO_data_in = d;
    pa = p && (model_q.size() < 8);
    qa = q && (model_q.size() > 0);
    if (p && !pa) m_err[1] = 1'b1;
    if (q && !qa) m_err[0] = 1'b1;
    if (qa) begin
      exp_q.push_back(model_q.pop_front());
      n_exp_pops++;
    end
    if (pa) model_q.push_back(d);
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
    check_flags();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_L && valid_out) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: data 0x%0h with no pop pending", FIFO_data_out);
      end else begin
        chk("read_data", 32'(FIFO_data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    push = 0; pop = 0; FIFO_data_in = '0; m_err = 2'b00;
    reset_L = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_L = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_data", 32'(FIFO_data_out), 32'h00);
    chk("rst_valid", 32'(valid_out), 32'd0);

    // three words in, three out
    step(1, 0, 8'hFF); step(1, 0, 8'hAF); step(1, 0, 8'h17);
    step(0, 1, 8'h00); chk("t2_valid1", 32'(valid_out), 32'd1);
    step(0, 1, 8'h00); chk("t2_valid2", 32'(valid_out), 32'd1);
    step(0, 1, 8'h00); chk("t2_valid3", 32'(valid_out), 32'd1);
    chk("t2_last_data", 32'(FIFO_data_out), 32'h17);
    chk("t2_empty", 32'(empty), 32'd1);
    step(0, 0, 8'h00); chk("t2_valid_drop", 32'(valid_out), 32'd0);

    // fill to full, overflow, drain
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'(i));
      if (i == 4) chk("t3_af_below", 32'(almost_full), 32'd0);
      if (i == 5) chk("t3_af_at6", 32'(almost_full), 32'd1);
    end
    chk("t3_full", 32'(full), 32'd1);
    step(1, 0, 8'hAA);
    chk("t3_count_held", 32'(fifo_count), 32'd8);
`ifdef FIFO_ERROR_FLAGS_EN
    chk("t3_error", 32'(error), 32'b10);
`else
    chk("t3_error", 32'(error), 32'b00);
`endif
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    // pop on empty
    step(0, 1, 8'h00);
    chk("t4_valid", 32'(valid_out), 32'd0);
    chk("t4_data_hold", 32'(FIFO_data_out), 32'h07);
`ifdef FIFO_ERROR_FLAGS_EN
    chk("t4_error", 32'(error), 32'b11);
`else
    chk("t4_error", 32'(error), 32'b00);
`endif

    // steady push+pop across pointer wrap
    for (int i = 0; i < 4; i++) step(1, 0, 8'h40 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 8'h50 + 8'(i));
      chk("t5_count4", 32'(fifo_count), 32'd4);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    // async reset mid-stream
    for (int i = 0; i < 5; i++) step(1, 0, 8'hC0 + 8'(i));
    chk("t6_count5", 32'(fifo_count), 32'd5);
    @(negedge clk);
    #2 reset_L = 1'b0;
    #1;
    chk("t6_rst_count", 32'(fifo_count), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("t6_rst_full", 32'(full), 32'd0);
    chk("t6_rst_almost_full", 32'(almost_full), 32'd0);
    chk("t6_rst_data", 32'(FIFO_data_out), 32'h00);
    chk("t6_rst_valid", 32'(valid_out), 32'd0);
    chk("t6_rst_error", 32'(error), 32'd0);
    model_q.delete();
    m_err = 2'b00;
    @(negedge clk);
    reset_L = 1'b1;
    step(0, 1, 8'h00);
    chk("t6_post_valid", 32'(valid_out), 32'd0);

    // drain check with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_exp_q", 32'(exp_q.size()), 32'd0);
    chk("valid_total", 32'(n_valid), 32'(n_exp_pops));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
